// File: rtl/data_ram_responder.sv
// Data-memory responder: one request at a time, configurable wait states,
// byte-lane-masked writes, full-word reads, single-cycle ack.
module data_ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dram_ce_i,
  input  logic        dram_we_i,
  input  logic [31:0] dram_addr_i,
  input  logic [31:0] dram_data_i,
  input  logic [3:0]  dram_sel_i,
  output logic [31:0] dram_data_o,
  output logic        dram_ack_o,
  output logic        dram_busy_o,
  output logic        dram_err_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  req_we, req_we_nxt;
  logic [29:0]           req_word, req_word_nxt;
  logic [31:0]           req_data, req_data_nxt;
  logic [3:0]            req_sel, req_sel_nxt;
  logic [31:0]           data_nxt;
  logic                  ack_nxt, err_nxt;
  logic [ADDR_WIDTH-1:0] idx_c;
  logic                  oor_c;
  logic                  access_c;
  logic                  wr_en_c;
  logic                  unused_addr_lsb;

  logic [31:0] mem [DEPTH];

  // Byte-offset bits never select anything: accesses are word-granular.
  assign unused_addr_lsb = ^dram_addr_i[1:0];

  assign idx_c       = req_word[ADDR_WIDTH-1:0];
  assign oor_c       = (req_word >> ADDR_WIDTH) != '0;
  assign access_c    = (state == WAIT) && (cnt == '0);
  assign wr_en_c     = access_c && req_we && !oor_c;
  assign dram_busy_o = (state != IDLE);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    req_we_nxt   = req_we;
    req_word_nxt = req_word;
    req_data_nxt = req_data;
    req_sel_nxt  = req_sel;
    data_nxt     = dram_data_o;
    ack_nxt      = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (dram_ce_i) begin
          req_we_nxt   = dram_we_i;
          req_word_nxt = dram_addr_i[31:2];
          req_data_nxt = dram_data_i;
          req_sel_nxt  = dram_sel_i;
          cnt_nxt      = CNT_W'(WAIT_CYCLES);
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = DONE;
          ack_nxt   = 1'b1;
          err_nxt   = oor_c;
          if (!req_we) begin
            data_nxt = oor_c ? 32'h0 : mem[idx_c];
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_we      <= 1'b0;
      req_word    <= '0;
      req_data    <= '0;
      req_sel     <= '0;
      dram_data_o <= '0;
      dram_ack_o  <= 1'b0;
      dram_err_o  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      req_we      <= req_we_nxt;
      req_word    <= req_word_nxt;
      req_data    <= req_data_nxt;
      req_sel     <= req_sel_nxt;
      dram_data_o <= data_nxt;
      dram_ack_o  <= ack_nxt;
      dram_err_o  <= err_nxt;
    end
  end

  // Array is never reset; a reset forces IDLE, so no write can complete.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (req_sel[i]) begin
          mem[idx_c][8*i +: 8] <= req_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/data_ram_responder.md
Name:
data_ram_responder

Overview:
- Memory-side responder for the CPU data-memory port (addr/wdata/we/sel/ce out of the mem stage, read data back).
- Accepts one request at a time, models a configurable-latency synchronous data SRAM, and performs byte-lane-masked writes and full-word reads.
- Signals completion with a one-cycle ack pulse.
- Sits between the core's dram interface and the on-chip data RAM in the SoC top and in simulation benches.

Parameters:
ADDR_WIDTH, 10, word-index width; memory depth = 2^ADDR_WIDTH 32-bit words.
WAIT_CYCLES, 2, extra wait states before the access; range 0..15.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
dram_ce_i  input  1  request valid from CPU mem stage
dram_we_i  input  1  1 = write, 0 = read
dram_addr_i  input  32  byte address; bits [1:0] ignored
dram_data_i  input  32  write data
dram_sel_i  input  4  byte-lane enables; bit i enables data[8i+7:8i]
dram_data_o  output  32  read data; valid while dram_ack_o=1 for a read
dram_ack_o  output  1  one-cycle completion pulse
dram_busy_o  output  1  high while a request is in flight
dram_err_o  output  1  high with ack when the address was out of range

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, dram_data_o=0, dram_ack_o=0, dram_err_o=0.
  - Latched request fields are cleared.
  - Memory array is not cleared.
- Reset mid-request aborts it: no write is performed and no ack is issued.
- Width of cnt = max(1, clog2(WAIT_CYCLES+1)).
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If dram_ce_i=1 at the edge: latch we, addr, data and sel; set cnt<=WAIT_CYCLES; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If cnt!=0: cnt<=cnt-1 and stay in WAIT.
  - If cnt==0: perform the access, set dram_ack_o<=1, go to DONE.
- DONE:
  - dram_ack_o is high for exactly this cycle.
  - The next edge clears ack/err and returns to IDLE.
  - dram_ce_i sampled in DONE is ignored.
- Latency: the request is sampled at edge E0; ack is high in the cycle following edge E0+WAIT_CYCLES+1, i.e. WAIT_CYCLES+2 cycles after the request.
  - WAIT_CYCLES=0 gives 2 cycles.
- Maximum throughput: one request per WAIT_CYCLES+3 cycles.
- dram_busy_o = (state != IDLE), combinational from the state register.
- Requests presented while busy are not queued. The CPU holds ce/addr/data stable until ack; only values latched in IDLE are used.
- Word index = latched addr[ADDR_WIDTH+1:2].
- Out of range: latched addr[31:ADDR_WIDTH+2] != 0.
  - Write is suppressed.
  - Read returns dram_data_o=0.
  - dram_err_o=1 together with ack.
- Write:
  - For each i in 0..3 with sel[i]=1, mem[idx][8i+7:8i] <= data[8i+7:8i]. Other lanes are unchanged.
  - sel=0000 still completes with ack and changes no bytes.
  - dram_data_o keeps its previous value.
- Read:
  - dram_data_o <= mem[idx] as a full word, regardless of sel; byte extraction is done by the CPU.
  - dram_data_o holds its value after DONE until the next read completes.
- The access reads the array contents as of the access edge, so a read after a completed write returns the new data.

Test Plan:
- WAIT_CYCLES=2: write addr 0x10, data 0xDEADBEEF, sel 1111; then read 0x10 -> each ack arrives 4 cycles after ce; read returns 0xDEADBEEF; err=0.
- Byte lanes: preload 0x11223344 at 0x20, write data 0xAABBCCDD with sel 0101, then read -> 0x11BB33DD.
- Out of range (ADDR_WIDTH=10): read 0x00001000 -> ack with err=1 and data_o=0.
  - A write to the same address leaves the word at 0x0 unchanged.
- ce held high continuously with changing addr: only the addr latched in IDLE is used.
  - busy stays 1 from the cycle after acceptance through DONE.
  - Next acceptance happens the cycle after DONE; exactly one ack per accepted request.
- Reset mid-WAIT: write 0xCAFEBABE to 0x30, pull rst low 1 cycle after ce -> no ack; outputs are 0 immediately.
  - A subsequent read of 0x30 returns the old content.
- WAIT_CYCLES=0: back-to-back read requests -> ack 2 cycles after each accepted ce; one request per 3 cycles.
